// File: rtl/cache_line_fill_if.sv
// Bundle of request, way-array and memory-port signals for the line-fill engine.
// slave = engine side, master = controller/array/memory side.
interface cache_line_fill_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [1:0]  req_way;
    logic        req_dirty;
    logic [15:0] req_victim_addr;

    logic [3:0]  way_sel;
    logic        way_enable;
    logic        way_we;
    logic [11:0] way_addr;
    logic [7:0]  way_data;
    logic [7:0]  way_dout;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_write;
    logic [15:0] mem_req_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;
    logic        done;

    modport slave (
        input  req_valid, req_addr, req_way, req_dirty, req_victim_addr,
        input  way_dout, mem_req_ready, mem_wready, mem_rdata, mem_rvalid,
        output req_ready, way_sel, way_enable, way_we, way_addr, way_data,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_wdata, mem_wvalid, done
    );

    modport master (
        output req_valid, req_addr, req_way, req_dirty, req_victim_addr,
        output way_dout, mem_req_ready, mem_wready, mem_rdata, mem_rvalid,
        input  req_ready, way_sel, way_enable, way_we, way_addr, way_data,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_wdata, mem_wvalid, done
    );
endinterface

// File: rtl/cache_line_fill.sv
// Line-fill engine: fetches a 16-byte line from memory into one way of a 4-way set array.
// Dirty-victim eviction is built only when LINE_WRITEBACK_EN is defined.
module cache_line_fill (
    input  logic             clk,
    input  logic             rst,
    cache_line_fill_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
`ifdef LINE_WRITEBACK_EN
        WB_REQ,
        WB_DATA,
`endif
        FILL_REQ,
        FILL_DATA,
        FILL_LAST,
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic [11:0] line_q;
    logic [1:0]  way_q;
    logic [3:0]  cnt;
    logic        we_q;
    logic [7:0]  wdata_q;
    logic [11:0] waddr_q;
    logic        accept, fbeat, wbeat;
    logic        unused_bits;

    assign accept = (state == IDLE) && bus.req_valid;
    assign fbeat  = (state == FILL_DATA) && bus.mem_rvalid;

`ifdef LINE_WRITEBACK_EN
    logic [11:0] victim_q;
    assign wbeat       = (state == WB_DATA) && bus.mem_wready;
    assign unused_bits = ^{bus.req_addr[3:0], bus.req_victim_addr[3:0]};
`else
    assign wbeat       = 1'b0;
    assign unused_bits = ^{bus.req_addr[3:0], bus.req_dirty, bus.req_victim_addr,
                           bus.way_dout, bus.mem_wready};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            line_q  <= '0;
            way_q   <= '0;
            cnt     <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            waddr_q <= '0;
`ifdef LINE_WRITEBACK_EN
            victim_q <= '0;
`endif
        end else begin
            state <= state_nxt;
            // Fill writes are registered: a beat is written on the cycle after it arrives.
            we_q  <= fbeat;
            if (accept) begin
                line_q <= bus.req_addr[15:4];
                way_q  <= bus.req_way;
                cnt    <= '0;
`ifdef LINE_WRITEBACK_EN
                victim_q <= bus.req_victim_addr[15:4];
`endif
            end else if (fbeat || wbeat) begin
                cnt <= cnt + 4'd1;
            end
            if (fbeat) begin
                wdata_q <= bus.mem_rdata;
                waddr_q <= {line_q[7:0], cnt};
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
`ifdef LINE_WRITEBACK_EN
                    state_nxt = bus.req_dirty ? WB_REQ : FILL_REQ;
`else
                    state_nxt = FILL_REQ;
`endif
                end
            end
`ifdef LINE_WRITEBACK_EN
            WB_REQ:    if (bus.mem_req_ready) state_nxt = WB_DATA;
            WB_DATA:   if (wbeat && cnt == 4'hF) state_nxt = FILL_REQ;
`endif
            FILL_REQ:  if (bus.mem_req_ready) state_nxt = FILL_DATA;
            FILL_DATA: if (fbeat && cnt == 4'hF) state_nxt = FILL_LAST;
            FILL_LAST: state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready     = (state == IDLE);
        bus.way_enable    = (state != IDLE);
        bus.way_sel       = (state == IDLE) ? 4'b0000 : (4'b0001 << way_q);
        bus.way_we        = we_q;
        bus.way_data      = wdata_q;
        bus.way_addr      = waddr_q;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_write = 1'b0;
        bus.mem_req_addr  = '0;
        bus.mem_wdata     = '0;
        bus.mem_wvalid    = 1'b0;
        bus.done          = (state == DONE);
        case (state)
`ifdef LINE_WRITEBACK_EN
            WB_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_write = 1'b1;
                bus.mem_req_addr  = {victim_q, 4'h0};
            end
            // Evict bytes stream straight from the way's combinational read port.
            WB_DATA: begin
                bus.way_addr   = {line_q[7:0], cnt};
                bus.mem_wdata  = bus.way_dout;
                bus.mem_wvalid = 1'b1;
            end
`endif
            FILL_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = {line_q, 4'h0};
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cache_line_fill.sv
// Randomized bench for cache_line_fill: memory and way arrays are modelled as byte arrays,
// and every fill is checked beat-by-beat and as a whole line against the memory image.
module tb_cache_line_fill;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_line_fill_if bus();
    cache_line_fill dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs = 0;
    int checks = 0;

    logic [7:0] mem  [0:65535];
    logic [7:0] ways [0:3][0:4095];

    typedef struct {
        int          due;
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t wq[$];

    function automatic int widx(input logic [3:0] s);
        case (s)
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return 0;
        endcase
    endfunction

    always_comb bus.way_dout = ways[widx(bus.way_sel)][bus.way_addr];

    function automatic logic [63:0] outs();
        return 64'({bus.way_sel, bus.way_enable, bus.way_we, bus.way_addr, bus.way_data,
                    bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr, bus.mem_wdata,
                    bus.mem_wvalid, bus.done});
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete request; gap<0 means random gaps, wmode 0=random/1=toggle/2=always wready.
    task automatic run_fill(input logic [15:0] a, input logic [1:0] w, input logic d,
                            input logic [15:0] v, input int gap, input int stall,
                            input int wmode, input int rst_beat, input int exp_lat);
        logic [7:0] old [16];
        int phase, beat, wbi, gapcnt, stallcnt, t0, last_edge, mism;
        bit de, fin, wr;
        de = d;
`ifndef LINE_WRITEBACK_EN
        de = 1'b0;
`endif
        for (int i = 0; i < 16; i++) old[i] = ways[w][{a[11:4], 4'(i)}];
        @(negedge clk);
        chk("req_ready", 64'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_addr = a;
        bus.req_way = w;
        bus.req_dirty = d;
        bus.req_victim_addr = v;
        phase = de ? 0 : 2;
        beat = 0; wbi = 0; gapcnt = 0; stallcnt = stall; last_edge = -10; fin = 0; t0 = -1;
        for (int it = 0; it < 600 && !fin; it++) begin
            @(negedge clk);
            if (t0 < 0) t0 = cyc;
            bus.req_valid = 1'b0;
            if (rst_beat >= 0 && beat == rst_beat + 1 && cyc == last_edge) begin
                rst = 1'b1;
                #1;
                chk("rst_we", 64'(bus.way_we), 0);
                chk("rst_ready", 64'(bus.req_ready), 1);
                chk("rst_outs", outs(), 0);
                wq.delete();
                bus.mem_rvalid = 1'b0;
                bus.mem_req_ready = 1'b0;
                bus.mem_wready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            chk("busy_ready", 64'(bus.req_ready), 0);
            if (bus.way_we) begin
                if (wq.size() > 0 && wq[0].due == cyc) begin
                    chk("we_addr", 64'(bus.way_addr), 64'(wq[0].a));
                    chk("we_data", 64'(bus.way_data), 64'(wq[0].d));
                    chk("we_sel", 64'(bus.way_sel), 64'(4'b0001 << w));
                    void'(wq.pop_front());
                end else begin
                    chk("extra_we", 1, 0);
                end
                ways[widx(bus.way_sel)][bus.way_addr] = bus.way_data;
            end else if (wq.size() > 0 && wq[0].due <= cyc) begin
                chk("missing_we", 0, 1);
                void'(wq.pop_front());
            end
            if (bus.done) begin
                chk("done_time", 64'(cyc), 64'(last_edge + 1));
                if (exp_lat > 0) chk("latency", 64'(cyc - t0 + 1), 64'(exp_lat));
                fin = 1;
            end
            // Responder: inputs for the next edge; stray rvalid/wready are noise the engine must ignore.
            bus.mem_req_ready = 1'b0;
            bus.mem_rvalid = 1'($urandom);
            bus.mem_rdata = 8'($urandom);
            bus.mem_wready = 1'($urandom);
            if (phase == 0 || phase == 2) begin
                chk("mreq_valid", 64'(bus.mem_req_valid), 1);
                chk("mreq_write", 64'(bus.mem_req_write), 64'(phase == 0));
                chk("mreq_addr", 64'(bus.mem_req_addr),
                    phase == 0 ? 64'({v[15:4], 4'h0}) : 64'({a[15:4], 4'h0}));
                if (stallcnt > 0) stallcnt--;
                else begin
                    bus.mem_req_ready = 1'b1;
                    phase = phase + 1;
                    stallcnt = stall;
                end
            end else begin
                chk("mreq_idle", 64'(bus.mem_req_valid), 0);
                if (phase == 1) begin
                    chk("wvalid", 64'(bus.mem_wvalid), 1);
                    wr = (wmode == 1) ? cyc[0] : (wmode == 2) ? 1'b1 : 1'($urandom);
                    bus.mem_wready = wr;
                    if (wr) begin
                        chk("wdata", 64'(bus.mem_wdata), 64'(old[wbi]));
                        mem[{v[15:4], 4'(wbi)}] = bus.mem_wdata;
                        wbi++;
                        if (wbi == 16) phase = 2;
                    end
                end else begin
                    chk("wvalid_idle", 64'(bus.mem_wvalid), 0);
                    if (phase == 3) begin
                        if (gapcnt > 0) begin
                            gapcnt--;
                            bus.mem_rvalid = 1'b0;
                        end else begin
                            bus.mem_rvalid = 1'b1;
                            bus.mem_rdata = mem[{a[15:4], 4'(beat)}];
                            wq.push_back('{cyc + 1, {a[11:4], 4'(beat)}, bus.mem_rdata});
                            last_edge = cyc + 1;
                            beat++;
                            gapcnt = (gap < 0) ? int'($urandom_range(2)) : gap;
                            if (beat == 16) phase = 4;
                        end
                    end
                end
            end
        end
        if (!fin) chk("timeout", 0, 1);
        chk("wq_empty", 64'(wq.size()), 0);
        mism = 0;
        for (int i = 0; i < 16; i++)
            if (ways[w][{a[11:4], 4'(i)}] !== mem[{a[15:4], 4'(i)}]) mism++;
        chk("line", 64'(mism), 0);
        @(negedge clk);
        chk("done_pulse", 64'(bus.done), 0);
        chk("idle_ready", 64'(bus.req_ready), 1);
        chk("idle_we", 64'(bus.way_we), 0);
        bus.mem_rvalid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int wy = 0; wy < 4; wy++)
            for (int i = 0; i < 4096; i++) ways[wy][i] = 8'($urandom);
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_way = '0; bus.req_dirty = 1'b0;
        bus.req_victim_addr = '0; bus.mem_req_ready = 1'b0; bus.mem_wready = 1'b0;
        bus.mem_rdata = '0; bus.mem_rvalid = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(bus.req_ready), 1);
        chk("reset_outs", outs(), 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) mem[16'h3A50 + i] = 8'(i);
        run_fill(16'h3A50, 2'd2, 1'b0, 16'h0000, 0, 0, 2, -1, 19);
`ifdef LINE_WRITEBACK_EN
        for (int i = 0; i < 16; i++) ways[1][{8'hA5, 4'(i)}] = 8'(i) ^ 8'hFF;
        run_fill(16'h3A50, 2'd1, 1'b1, 16'h7A50, 0, 0, 1, -1, 0);
        run_fill(16'h1230, 2'd3, 1'b1, 16'h4560, 0, 0, 2, -1, 36);
`endif
        run_fill(16'hBEE0, 2'd0, 1'b0, 16'h0000, 3, 0, 2, -1, 0);
        run_fill(16'h5550, 2'd1, 1'b1, 16'h9990, 0, 5, 2, -1, 0);
        run_fill(16'hC0D0, 2'd3, 1'b0, 16'h0000, 0, 0, 2, 7, 0);
        run_fill(16'hC0D0, 2'd3, 1'b0, 16'h0000, 0, 0, 2, -1, 19);
        repeat (10)
            run_fill(16'($urandom), 2'($urandom), 1'($urandom), 16'($urandom),
                     -1, int'($urandom_range(3)), 0, -1, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
